// File: rtl/dma_mm2s_burst_engine.sv
// MM2S read engine: splits one beat-length command into 4 KB-safe AXI4 INCR bursts
// and streams the returned data onto AXI-Stream with a single transfer-level tlast.
module dma_mm2s_burst_engine #(
   parameter int DATA_WIDTH      = 64,
   parameter int ADDR_WIDTH      = 32,
   parameter int LEN_WIDTH       = 16,
   parameter int MAX_BURST_LEN   = 16,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                  m_axi_aclk,
   input  logic                  m_axi_areset,
   output logic [ADDR_WIDTH-1:0] m_mm2s_axi_araddr,
   output logic [7:0]            m_mm2s_axi_arlen,
   output logic [2:0]            m_mm2s_axi_arsize,
   output logic [1:0]            m_mm2s_axi_arburst,
   output logic [3:0]            m_mm2s_axi_arcache,
   output logic [2:0]            m_mm2s_axi_arprot,
   output logic                  m_mm2s_axi_arvalid,
   input  logic                  m_mm2s_axi_arready,
   input  logic [DATA_WIDTH-1:0] m_mm2s_axi_rdata,
   input  logic [1:0]            m_mm2s_axi_rresp,
   input  logic                  m_mm2s_axi_rlast,
   input  logic                  m_mm2s_axi_rvalid,
   output logic                  m_mm2s_axi_rready,
   output logic [DATA_WIDTH-1:0] m_mm2s_axis_tdata,
   output logic                  m_mm2s_axis_tvalid,
   output logic                  m_mm2s_axis_tlast,
   input  logic                  m_mm2s_axis_tready,
   input  logic                  read_start_i,
   input  logic [ADDR_WIDTH-1:0] read_addr_i,
   input  logic [LEN_WIDTH-1:0]  read_len_i,
   output logic                  read_busy_o,
   output logic                  read_done_o,
   output logic                  read_error_o
);

   localparam int SZ = $clog2(DATA_WIDTH / 8);
   localparam int CW = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr;
   logic [LEN_WIDTH-1:0]  len;
   logic [LEN_WIDTH-1:0]  rem;
   logic [LEN_WIDTH-1:0]  beats;
   logic [3:0]            outstanding;

   logic [12:0]           to_bound_bytes;
   logic [CW-1:0]         to_bound;
   logic [CW-1:0]         rem_w;
   logic [CW-1:0]         max_w;
   logic [CW-1:0]         b1;
   logic [CW-1:0]         burst;
   logic                  ar_hs;
   logic                  r_hs;
   logic                  last_beat;
   logic                  final_r;
   logic [3:0]            out_nxt;
   logic                  can_issue;

   assign m_mm2s_axi_arsize  = 3'(SZ);
   assign m_mm2s_axi_arburst = 2'b01;
   assign m_mm2s_axi_arcache = 4'b0011;
   assign m_mm2s_axi_arprot  = 3'b000;

   assign m_mm2s_axis_tdata  = m_mm2s_axi_rdata;
   assign m_mm2s_axis_tvalid = m_mm2s_axi_rvalid & read_busy_o;
   assign m_mm2s_axi_rready  = m_mm2s_axis_tready & read_busy_o;
   assign m_mm2s_axis_tlast  = m_mm2s_axis_tvalid & last_beat;

   // addr/rem track the next un-presented burst, so they advance when an AR is presented
   assign to_bound_bytes = 13'd4096 - {1'b0, addr[11:0]};
   assign to_bound       = CW'(to_bound_bytes >> SZ);
   assign rem_w          = CW'(rem);
   assign max_w          = CW'(MAX_BURST_LEN);
   assign b1             = (rem_w < max_w) ? rem_w : max_w;
   assign burst          = (b1 < to_bound) ? b1 : to_bound;

   assign ar_hs     = m_mm2s_axi_arvalid & m_mm2s_axi_arready;
   assign r_hs      = m_mm2s_axi_rvalid & m_mm2s_axi_rready;
   assign last_beat = (beats == (len - LEN_WIDTH'(1)));
   assign final_r   = r_hs & last_beat;
   assign out_nxt   = outstanding + {3'b000, ar_hs} - {3'b000, r_hs & m_mm2s_axi_rlast};
   assign can_issue = (rem != '0) && (out_nxt < 4'(MAX_OUTSTANDING));

   always_ff @(posedge m_axi_aclk) begin
      if (m_axi_areset) begin
         state              <= IDLE;
         addr               <= '0;
         len                <= '0;
         rem                <= '0;
         beats              <= '0;
         outstanding        <= '0;
         m_mm2s_axi_araddr  <= '0;
         m_mm2s_axi_arlen   <= '0;
         m_mm2s_axi_arvalid <= 1'b0;
         read_busy_o        <= 1'b0;
         read_done_o        <= 1'b0;
         read_error_o       <= 1'b0;
      end else begin
         read_done_o <= 1'b0;
         outstanding <= out_nxt;
         if (r_hs) begin
            beats <= beats + LEN_WIDTH'(1);
            if (m_mm2s_axi_rresp != 2'b00) read_error_o <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (read_start_i) begin
                  addr         <= read_addr_i;
                  len          <= read_len_i;
                  rem          <= read_len_i;
                  beats        <= '0;
                  outstanding  <= '0;
                  read_error_o <= 1'b0;
                  if (read_len_i != '0) begin
                     state       <= ISSUE;
                     read_busy_o <= 1'b1;
                  end else begin
                     state       <= DONE;
                     read_done_o <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (final_r) begin
                  state              <= DONE;
                  read_busy_o        <= 1'b0;
                  read_done_o        <= 1'b1;
                  m_mm2s_axi_arvalid <= 1'b0;
               end else if (ar_hs && rem == '0) begin
                  m_mm2s_axi_arvalid <= 1'b0;
                  state              <= DRAIN;
               end else if ((!m_mm2s_axi_arvalid || m_mm2s_axi_arready) && can_issue) begin
                  m_mm2s_axi_araddr  <= addr;
                  m_mm2s_axi_arlen   <= 8'(burst - CW'(1));
                  m_mm2s_axi_arvalid <= 1'b1;
                  addr               <= addr + (ADDR_WIDTH'(burst) << SZ);
                  rem                <= rem - LEN_WIDTH'(burst);
               end else if (ar_hs) begin
                  m_mm2s_axi_arvalid <= 1'b0;
               end
            end
            DRAIN: begin
               if (final_r) begin
                  state       <= DONE;
                  read_busy_o <= 1'b0;
                  read_done_o <= 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dma_mm2s_burst_engine.sv
// Directed bench for dma_mm2s_burst_engine with a small AXI read slave that returns
// address-derived data, plus a monitor logging AR, AXIS and completion events.
module tb_dma_mm2s_burst_engine;
   localparam int DW = 64;
   localparam int AW = 32;
   localparam int LW = 16;
   localparam logic [63:0] K = 64'hC0DE_0000_0000_0000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] araddr;
   logic [7:0]    arlen;
   logic [2:0]    arsize;
   logic [1:0]    arburst;
   logic [3:0]    arcache;
   logic [2:0]    arprot;
   logic          arvalid;
   logic          arready = 1'b1;
   logic [DW-1:0] rdata = '0;
   logic [1:0]    rresp = 2'b00;
   logic          rlast = 1'b0;
   logic          rvalid = 1'b0;
   logic          rready;
   logic [DW-1:0] tdata;
   logic          tvalid, tlast;
   logic          tready = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] saddr = '0;
   logic [LW-1:0] slen = '0;
   logic          busy, done, error;

   always #5 clk = ~clk;

   dma_mm2s_burst_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW),
                           .MAX_BURST_LEN(16), .MAX_OUTSTANDING(2)) dut (
      .m_axi_aclk(clk), .m_axi_areset(rst),
      .m_mm2s_axi_araddr(araddr), .m_mm2s_axi_arlen(arlen), .m_mm2s_axi_arsize(arsize),
      .m_mm2s_axi_arburst(arburst), .m_mm2s_axi_arcache(arcache), .m_mm2s_axi_arprot(arprot),
      .m_mm2s_axi_arvalid(arvalid), .m_mm2s_axi_arready(arready),
      .m_mm2s_axi_rdata(rdata), .m_mm2s_axi_rresp(rresp), .m_mm2s_axi_rlast(rlast),
      .m_mm2s_axi_rvalid(rvalid), .m_mm2s_axi_rready(rready),
      .m_mm2s_axis_tdata(tdata), .m_mm2s_axis_tvalid(tvalid), .m_mm2s_axis_tlast(tlast),
      .m_mm2s_axis_tready(tready),
      .read_start_i(start), .read_addr_i(saddr), .read_len_i(slen),
      .read_busy_o(busy), .read_done_o(done), .read_error_o(error)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   logic        r_en = 1'b1;
   logic        tog  = 1'b0;
   int          err_beat = -1;
   logic [31:0] q_addr[$];
   logic [7:0]  q_len[$];
   int          bi = 0, r_tot = 0, cyc = 0;
   logic [31:0] ar_addr[$];
   logic [7:0]  ar_len[$];
   int          ar_cyc[$], rl_cyc[$], ax_cyc[$];
   logic [63:0] ax_data[$];
   logic        ax_last[$];
   int          done_cnt = 0, done_cyc = 0, rr_bad = 0;

   // observe at negedge, update slave outputs just after posedge
   initial begin : slave
      logic        s_rst, s_ar, s_r;
      logic [31:0] s_aa;
      logic [7:0]  s_al;
      forever begin
         @(negedge clk);
         cyc++;
         s_rst = rst;
         s_ar  = arvalid & arready;
         s_aa  = araddr;
         s_al  = arlen;
         s_r   = rvalid & rready;
         if (!rst) begin
            if (s_ar) begin ar_addr.push_back(araddr); ar_len.push_back(arlen); ar_cyc.push_back(cyc); end
            if (s_r && rlast) rl_cyc.push_back(cyc);
            if (tvalid && tready) begin ax_data.push_back(tdata); ax_last.push_back(tlast); ax_cyc.push_back(cyc); end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (busy && (rready !== tready)) rr_bad++;
         end
         @(posedge clk); #1;
         if (s_rst) begin
            q_addr.delete(); q_len.delete(); bi = 0;
         end else begin
            if (s_r && q_addr.size() > 0) begin
               r_tot++;
               if (bi == int'(q_len[0])) begin
                  void'(q_addr.pop_front()); void'(q_len.pop_front()); bi = 0;
               end else bi++;
            end
            if (s_ar) begin q_addr.push_back(s_aa); q_len.push_back(s_al); end
         end
         if (r_en && q_addr.size() > 0) begin
            rvalid = 1'b1;
            rdata  = 64'(q_addr[0] + 32'(bi * 8)) ^ K;
            rlast  = (bi == int'(q_len[0]));
            rresp  = (r_tot == err_beat) ? 2'b10 : 2'b00;
         end else begin
            rvalid = 1'b0;
            rlast  = 1'b0;
            rresp  = 2'b00;
         end
         tready = tog ? ~tready : 1'b1;
      end
   end

   task automatic tick();
      @(negedge clk); #1;
   endtask

   task automatic clear_logs();
      ar_addr.delete(); ar_len.delete(); ar_cyc.delete(); rl_cyc.delete();
      ax_data.delete(); ax_last.delete(); ax_cyc.delete();
      done_cnt = 0; rr_bad = 0; r_tot = 0;
   endtask

   task automatic go(input logic [31:0] a, input logic [15:0] l);
      @(posedge clk); #1;
      start = 1'b1; saddr = a; slen = l;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = done_cnt;
      int t = 0;
      while (done_cnt == n && t < budget) begin tick(); t++; end
      chk({tag, "_timeout"}, 64'(done_cnt == n), 64'd0);
   endtask

   task automatic chk_ar(input string tag, input int idx, input logic [31:0] a, input logic [7:0] l);
      if (idx < ar_addr.size()) begin
         chk({tag, "_addr"}, 64'(ar_addr[idx]), 64'(a));
         chk({tag, "_len"}, 64'(ar_len[idx]), 64'(l));
      end else chk({tag, "_missing"}, 64'(ar_addr.size()), 64'(idx + 1));
   endtask

   task automatic chk_stream(input string tag, input logic [31:0] a, input int l);
      int bad = 0, nl = 0, li = -1;
      for (int i = 0; i < ax_data.size(); i++) begin
         if (ax_data[i] !== (64'(a + 32'(8 * i)) ^ K)) bad++;
         if (ax_last[i]) begin nl++; li = i; end
      end
      chk({tag, "_beats"}, 64'(ax_data.size()), 64'(l));
      chk({tag, "_data"}, 64'(bad), 64'd0);
      chk({tag, "_nlast"}, 64'(nl), 64'd1);
      chk({tag, "_lastidx"}, 64'(li), 64'(l - 1));
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_outs"}, 64'({arvalid, rready, tvalid, tlast, busy, done, error}), 64'd0);
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      int hit;
      int t;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      tick();
      chk_idle("reset");
      chk("consts", 64'({arsize, arburst, arcache, arprot}), 64'({3'd3, 2'b01, 4'b0011, 3'b000}));

      // aligned transfer, ready always high
      clear_logs();
      go(32'h1000, 16'd40);
      wait_done("t1", 600);
      chk("t1_busy_in_done", 64'(busy), 64'd0);
      chk("t1_nar", 64'(ar_addr.size()), 64'd3);
      chk_ar("t1_ar0", 0, 32'h1000, 8'd15);
      chk_ar("t1_ar1", 1, 32'h1080, 8'd15);
      chk_ar("t1_ar2", 2, 32'h1100, 8'd7);
      chk_stream("t1", 32'h1000, 40);
      chk("t1_err", 64'(error), 64'd0);
      tick();
      chk("t1_done_pulse", 64'(done), 64'd0);
      chk("t1_done_cnt", 64'(done_cnt), 64'd1);

      // 4 KB boundary split
      clear_logs();
      go(32'h0FF0, 16'd8);
      wait_done("t2", 300);
      chk("t2_nar", 64'(ar_addr.size()), 64'd2);
      chk_ar("t2_ar0", 0, 32'h0FF0, 8'd1);
      chk_ar("t2_ar1", 1, 32'h1000, 8'd5);
      chk_stream("t2", 32'h0FF0, 8);

      // outstanding limit with R stalled
      r_en = 1'b0;
      clear_logs();
      go(32'h4000, 16'd64);
      repeat (50) tick();
      chk("t3_nar_held", 64'(ar_addr.size()), 64'd2);
      chk("t3_arvalid_held", 64'(arvalid), 64'd0);
      r_en = 1'b1;
      wait_done("t3", 1000);
      chk("t3_nar", 64'(ar_addr.size()), 64'd4);
      hit = 0;
      if (ar_cyc.size() > 2 && rl_cyc.size() > 0) hit = (ar_cyc[2] > rl_cyc[0]) ? 1 : 0;
      chk("t3_ar2_after_rlast", 64'(hit), 64'd1);
      chk_stream("t3", 32'h4000, 64);

      // tready toggling
      tog = 1'b1;
      clear_logs();
      go(32'h6000, 16'd16);
      wait_done("t4", 400);
      tog = 1'b0;
      chk("t4_rready_mirror", 64'(rr_bad), 64'd0);
      chk_stream("t4", 32'h6000, 16);
      hit = 0;
      if (ax_cyc.size() > 0) hit = done_cyc - ax_cyc[ax_cyc.size() - 1];
      chk("t4_done_after_last", 64'(hit), 64'd1);

      // error response on beat 3, sticky until next start
      err_beat = 2;
      clear_logs();
      go(32'h5000, 16'd8);
      wait_done("t5", 300);
      chk_stream("t5", 32'h5000, 8);
      chk("t5_err_set", 64'(error), 64'd1);
      repeat (3) tick();
      chk("t5_err_sticky", 64'(error), 64'd1);
      err_beat = -1;
      clear_logs();
      go(32'h5100, 16'd8);
      wait_done("t5b", 300);
      chk("t5_err_cleared", 64'(error), 64'd0);

      // zero-length command
      clear_logs();
      go(32'h7000, 16'd0);
      tick();
      chk("t6_len0_done", 64'(done_cnt), 64'd1);
      chk("t6_len0_nar", 64'(ar_addr.size()), 64'd0);
      chk("t6_len0_busy", 64'(busy), 64'd0);

      // ignored restart, then reset mid-transfer
      clear_logs();
      go(32'h2000, 16'd32);
      repeat (3) tick();
      go(32'h8000, 16'd5);
      t = 0;
      while (ax_data.size() < 9 && t < 300) begin tick(); t++; end
      chk("t7_reach_beat10_timeout", 64'(ax_data.size() < 9), 64'd0);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      tick();
      chk_idle("t7_rst");
      hit = 0;
      foreach (ar_addr[i]) if (ar_addr[i] == 32'h8000) hit++;
      chk("t7_no_extra_ar", 64'(hit), 64'd0);
      chk("t7_nar_pre_rst", 64'(ar_addr.size()), 64'd2);
      tick();
      clear_logs();
      go(32'h2000, 16'd32);
      wait_done("t7b", 600);
      chk("t7b_nar", 64'(ar_addr.size()), 64'd2);
      chk_ar("t7b_ar0", 0, 32'h2000, 8'd15);
      chk_ar("t7b_ar1", 1, 32'h2080, 8'd15);
      chk_stream("t7b", 32'h2000, 32);
      chk("t7b_err", 64'(error), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/dma_mm2s_burst_engine.md
Name: dma_mm2s_burst_engine

Overview:
- Next-generation MM2S read engine for the DMA.
- Accepts one transfer command of arbitrary beat length (up to 2^LEN_WIDTH-1 beats) and splits it into AXI4 INCR bursts of at most MAX_BURST_LEN beats that never cross a 4 KB boundary.
- Keeps up to MAX_OUTSTANDING read bursts in flight and streams returned data onto AXI-Stream.
- Asserts tlast only on the final beat of the whole transfer; reports completion and a sticky response error.

Parameters:
DATA_WIDTH, 64, AXI/AXIS data width in bits; power of two, 32..512
ADDR_WIDTH, 32, AXI address width
LEN_WIDTH, 16, width of the transfer length in beats
MAX_BURST_LEN, 16, maximum beats per AR burst; 1..256
MAX_OUTSTANDING, 4, maximum accepted-but-incomplete AR bursts; 1..15

Ports:
m_axi_aclk  in  1  clock
m_axi_areset  in  1  synchronous active-high reset
m_mm2s_axi_araddr  out  ADDR_WIDTH  burst start address
m_mm2s_axi_arlen  out  8  beats-1
m_mm2s_axi_arsize  out  3  constant log2(DATA_WIDTH/8)
m_mm2s_axi_arburst  out  2  constant 2'b01 (INCR)
m_mm2s_axi_arcache  out  4  constant 4'b0011
m_mm2s_axi_arprot  out  3  constant 3'b000
m_mm2s_axi_arvalid  out  1  address valid
m_mm2s_axi_arready  in  1  address ready
m_mm2s_axi_rdata  in  DATA_WIDTH  read data
m_mm2s_axi_rresp  in  2  read response
m_mm2s_axi_rlast  in  1  last beat of burst
m_mm2s_axi_rvalid  in  1  read valid
m_mm2s_axi_rready  out  1  read ready
m_mm2s_axis_tdata  out  DATA_WIDTH  stream data
m_mm2s_axis_tvalid  out  1  stream valid
m_mm2s_axis_tlast  out  1  final beat of transfer
m_mm2s_axis_tready  in  1  stream ready
read_start_i  in  1  command strobe
read_addr_i  in  ADDR_WIDTH  start byte address; must be beat-aligned
read_len_i  in  LEN_WIDTH  transfer length in beats
read_busy_o  out  1  transfer in progress
read_done_o  out  1  one-cycle completion pulse
read_error_o  out  1  sticky: some rresp != 2'b00 in last transfer

Behaviour:
- Reset (synchronous, m_axi_areset=1):
  - arvalid, rready, tvalid, tlast, busy, done and error all go to 0.
  - All counters clear and the FSM returns to IDLE.
  - A reset mid-transfer abandons it; any R beats still in flight are the system's responsibility.
- FSM states:
  - IDLE -> ISSUE on read_start_i with read_len_i != 0.
  - ISSUE -> DRAIN when the last AR handshakes.
  - DRAIN -> DONE when the final R beat handshakes.
  - DONE -> IDLE after one cycle.
  - ISSUE may also exit directly to DONE if the final R beat lands in the same cycle as, or before, the last AR; this is not normally reachable.
- Start:
  - Sampled only in IDLE; ignored while busy.
  - Latches addr and len, clears read_error_o, and sets busy on the next cycle.
  - read_len_i = 0: no AR is issued; read_done_o pulses the next cycle; busy stays 0.
- Burst size:
  - to_boundary = (4096 - addr[11:0]) >> log2(DATA_WIDTH/8).
  - burst = min(remaining_ar_beats, MAX_BURST_LEN, to_boundary).
  - arlen = burst-1.
  - On AR handshake: addr += burst*bytes and remaining_ar_beats -= burst.
  - The next AR may be presented the cycle after a handshake; arvalid is registered.
  - araddr/arlen are stable while arvalid=1 and arready=0.
- Outstanding count:
  - +1 on AR handshake, -1 on R handshake with rlast; both in the same cycle leaves it unchanged.
  - arvalid is asserted only when outstanding < MAX_OUTSTANDING.
- Data path:
  - Combinational pass-through: tdata=rdata, tvalid=rvalid & busy, rready=tready & busy.
  - Zero added latency; tready backpressure stalls R.
- tlast:
  - Asserted on the beat where beats_received == len-1.
  - Independent of rlast; internal rlast boundaries are not forwarded.
- Error:
  - Any R handshake with rresp != 0 sets read_error_o.
  - Data is still forwarded and the transfer completes normally.
  - read_error_o holds until the next accepted start or reset.
- Completion: read_done_o pulses one cycle in DONE; busy drops in that same cycle.

Test Plan:
- DATA_WIDTH=64, MAX_BURST_LEN=16, addr 0x1000, len 40, ready always high -> AR (0x1000,15),(0x1080,15),(0x1100,7); 40 AXIS beats, tlast on beat 40 only; done 1 cycle; error 0.
- addr 0x0FF0, len 8 -> AR (0x0FF0,1) then (0x1000,5); no burst crosses 0x1000; tlast on beat 8.
- MAX_OUTSTANDING=2, len 64, rvalid held low for 50 cycles -> exactly 2 AR accepted; third AR appears only after first burst's rlast handshake.
- tready toggling 1/0 every cycle, len 16 -> rready mirrors tready; data order and values preserved; done after 16th handshake.
- rresp=2'b10 on beat 3 of len 8 -> all 8 beats forwarded, read_error_o=1 after done; next start with OKAY responses clears it to 0.
- Two tests share one transfer (addr 0x2000, len 32):
  - start pulsed again mid-transfer -> ignored, no extra AR.
  - reset asserted at beat 10 -> all outputs 0 next cycle; new start then runs cleanly.
